// File: rtl/trng_pkg.sv
// Shared types and default sizing for the ring-oscillator random word collector.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    COLLECT = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int WORD_W_DEF     = 8;
  localparam int SAMPLE_DIV_DEF = 4;
  localparam int WARMUP_CYC_DEF = 16;
  localparam int REP_LIMIT_DEF  = 32;

endpackage

// File: rtl/trng_collector_vn_debias.sv
// Von Neumann pair extractor: (a,b) with a!=b emits a, equal pairs are dropped.
// Outputs are registered, so a result appears the clock after the second sample.
module vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic bit_in,
  input  logic clear,
  output logic out_valid,
  output logic out_bit
);

  logic have_a;
  logic a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_a    <= 1'b0;
      a         <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else if (clear) begin
      have_a    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample) begin
        if (!have_a) begin
          a      <= bit_in;
          have_a <= 1'b1;
        end else begin
          have_a    <= 1'b0;
          out_valid <= a ^ bit_in;
          out_bit   <= a;
        end
      end
    end
  end

endmodule

// File: rtl/trng_collector.sv
// Ring-oscillator consumer: warmup, divided sampling, von Neumann debias, word handoff.
// Define TRNG_HEALTH_EN to add the repetition-count health test and sticky FAULT state.
module trng_collector
  import trng_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int WARMUP_CYC = WARMUP_CYC_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              raw_bit,
  output logic              osc_run,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [WORD_W-1:0] rnd_data,
  output logic              fault
);

  if (WORD_W < 2 || WORD_W > 32) begin : g_bad_word_w
    $error("WORD_W must be 2..32");
  end
  if (SAMPLE_DIV < 1) begin : g_bad_div
    $error("SAMPLE_DIV must be >= 1");
  end
  if (WARMUP_CYC < 1) begin : g_bad_warm
    $error("WARMUP_CYC must be >= 1");
  end
  if (REP_LIMIT < 2) begin : g_bad_rep
    $error("REP_LIMIT must be >= 2");
  end

  localparam int WCW = $clog2(WARMUP_CYC + 1);
  localparam int DCW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD_W + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYC - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);

  state_t            state, next_state;
  logic [WCW-1:0]    warm_cnt;
  logic [DCW-1:0]    div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [WORD_W-1:0] word;
  logic              strobe;
  logic              vn_valid, vn_bit;
  logic              word_done;
  logic              rep_hit;

  assign strobe    = (state == COLLECT) && (div_cnt == DIV_LAST);
  assign word_done = (state == COLLECT) && vn_valid && (bit_cnt == BIT_LAST);

  // Pair state lives in the extractor; holding it in clear outside COLLECT
  // drops any half pair when collection is abandoned.
  vn_debias u_vn (
    .clk       (clk),
    .reset     (reset),
    .sample    (strobe),
    .bit_in    (raw_bit),
    .clear     (state != COLLECT),
    .out_valid (vn_valid),
    .out_bit   (vn_bit)
  );

`ifdef TRNG_HEALTH_EN
  localparam int RCW = $clog2(REP_LIMIT + 1);
  localparam logic [RCW-1:0] REP_MAX = RCW'(REP_LIMIT);

  logic [RCW-1:0] run_cnt;
  logic           prev_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt  <= '0;
      prev_bit <= 1'b0;
    end else if (state != COLLECT) begin
      run_cnt  <= '0;
    end else if (strobe) begin
      prev_bit <= raw_bit;
      if (run_cnt == '0 || raw_bit != prev_bit) run_cnt <= RCW'(1);
      else if (run_cnt != REP_MAX)              run_cnt <= run_cnt + 1'b1;
    end
  end

  assign rep_hit = (state == COLLECT) && (run_cnt == REP_MAX);
`else
  assign rep_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable) next_state = WARMUP;
      WARMUP: begin
        if (!enable)                    next_state = IDLE;
        else if (warm_cnt == WARM_LAST) next_state = COLLECT;
      end
      // A stuck source outranks a word finishing on the same strobe.
      COLLECT: begin
        if (rep_hit)        next_state = FAULT;
        else if (!enable)   next_state = IDLE;
        else if (word_done) next_state = HOLD;
      end
      HOLD:    if (rnd_ready) next_state = enable ? WARMUP : IDLE;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    osc_run   = (state == WARMUP) || (state == COLLECT);
    rnd_valid = (state == HOLD);
`ifdef TRNG_HEALTH_EN
    fault     = (state == FAULT);
`else
    fault     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      word     <= '0;
      rnd_data <= '0;
    end else begin
      warm_cnt <= (state == WARMUP) ? warm_cnt + 1'b1 : '0;
      if (state != COLLECT) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        word    <= '0;
      end else begin
        div_cnt <= strobe ? '0 : div_cnt + 1'b1;
        if (vn_valid) begin
          word    <= {word[WORD_W-2:0], vn_bit};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (next_state == HOLD && state == COLLECT)
        rnd_data <= {word[WORD_W-2:0], vn_bit};
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Self-checking bench for trng_collector: sample-list reference model with random filler.
module tb_trng_collector;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int WU  = 16;
  localparam int REP = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         raw_bit = 1'b0;
  logic         rnd_ready = 1'b1;
  logic         osc_run, rnd_valid, fault;
  logic [W-1:0] rnd_data;

  int tests = 0;
  int fails = 0;

  bit samp[512];
  int nsamp;

  int           o_vcyc, o_fcyc, o_bad;
  logic [W-1:0] o_data;

  always #5 clk = ~clk;

  trng_collector #(.WORD_W(W), .SAMPLE_DIV(D), .WARMUP_CYC(WU), .REP_LIMIT(REP)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .raw_bit   (raw_bit),
    .osc_run   (osc_run),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .fault     (fault)
  );

  // Reference: the k-th raw sample is seen WU + D*(k+1) clocks after enable.
  task automatic vn_model(output logic [W-1:0] w, output int vcyc, output int fcyc);
    int nb  = 0;
    int run = 0;
    w = '0; vcyc = -1; fcyc = -1;
    for (int k = 0; k < nsamp; k++) begin
      run = (k > 0 && samp[k] == samp[k-1]) ? run + 1 : 1;
`ifdef TRNG_HEALTH_EN
      if (run >= REP) fcyc = WU + D*(k+1) + 1;
`endif
      if (fcyc < 0 && (k % 2) == 1 && samp[k-1] != samp[k]) begin
        w = {w[W-2:0], samp[k-1]};
        nb++;
        if (nb == W) vcyc = WU + D*(k+1) + 1;
      end
      if (vcyc >= 0 || fcyc >= 0) break;
    end
  endtask

  // Drives enable=1 from IDLE, places samp[] on the sample clocks and random
  // bits elsewhere; stops at the first rnd_valid or fault, or after max_cyc.
  task automatic drive_run(input int max_cyc);
    o_vcyc = -1; o_fcyc = -1; o_bad = 0; o_data = '0;
    enable = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      int rel = c - WU;
      if (rel > 0 && rel % D == 0 && rel / D - 1 < nsamp) raw_bit = samp[rel/D - 1];
      else raw_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (rnd_valid) begin o_vcyc = c; o_data = rnd_data; break; end
      if (fault)     begin o_fcyc = c; break; end
      if (osc_run !== 1'b1) o_bad++;
    end
  endtask

  task automatic end_test();
    enable = 1'b0;
    rnd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_alt(input int n);
    nsamp = n;
    for (int p = 0; p < n / 2; p++) begin
      samp[2*p]   = (p % 2 == 0);
      samp[2*p+1] = (p % 2 != 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    tests++; if (osc_run !== 1'b0)  begin fails++; $display("FAIL reset_osc_run got=%b exp=0", osc_run); end
    tests++; if (rnd_valid !== 1'b0) begin fails++; $display("FAIL reset_rnd_valid got=%b exp=0", rnd_valid); end
    tests++; if (rnd_data !== '0)    begin fails++; $display("FAIL reset_rnd_data got=%h exp=00", rnd_data); end
    tests++; if (fault !== 1'b0)     begin fails++; $display("FAIL reset_fault got=%b exp=0", fault); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alternating();
    fill_alt(16);
    rnd_ready = 1'b1;
    drive_run(300);
    tests++; if (o_vcyc != WU + 16*D + 1) begin fails++; $display("FAIL alt_valid_cycle got=%0d exp=%0d", o_vcyc, WU + 16*D + 1); end
    tests++; if (o_data !== 8'hAA) begin fails++; $display("FAIL alt_data got=%h exp=aa", o_data); end
    tests++; if (o_bad != 0) begin fails++; $display("FAIL alt_osc_run_low got=%0d exp=0", o_bad); end
    @(posedge clk); #1;
    tests++; if (rnd_valid !== 1'b0 || osc_run !== 1'b1) begin
      fails++; $display("FAIL alt_after_accept valid=%b osc=%b exp valid=0 osc=1", rnd_valid, osc_run);
    end
    end_test();
  endtask

  task automatic test_discard();
    logic [W-1:0] ew; int ev, ef;
    nsamp = 18;
    samp[0] = 1'b1; samp[1] = 1'b1;
    for (int p = 1; p < 9; p++) begin samp[2*p] = 1'b1; samp[2*p+1] = 1'b0; end
    vn_model(ew, ev, ef);
    drive_run(300);
    tests++; if (o_vcyc != ev) begin fails++; $display("FAIL discard_valid_cycle got=%0d exp=%0d", o_vcyc, ev); end
    tests++; if (o_data !== 8'hFF) begin fails++; $display("FAIL discard_data got=%h exp=ff", o_data); end
    end_test();
  endtask

  task automatic test_random();
    logic [W-1:0] ew; int ev, ef;
    for (int it = 0; it < 4; it++) begin
      nsamp = 96;
      for (int k = 0; k < nsamp; k++) samp[k] = 1'($urandom_range(0, 1));
      vn_model(ew, ev, ef);
      drive_run(600);
      tests++; if (o_vcyc != ev) begin fails++; $display("FAIL rand%0d_valid_cycle got=%0d exp=%0d", it, o_vcyc, ev); end
      tests++; if (o_data !== ew) begin fails++; $display("FAIL rand%0d_data got=%h exp=%h", it, o_data, ew); end
      tests++; if (o_bad != 0) begin fails++; $display("FAIL rand%0d_osc_run_low got=%0d exp=0", it, o_bad); end
      end_test();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ew; int ev, ef; int errs = 0;
    nsamp = 96;
    for (int k = 0; k < nsamp; k++) samp[k] = 1'($urandom_range(0, 1));
    vn_model(ew, ev, ef);
    rnd_ready = 1'b0;
    drive_run(600);
    tests++; if (o_data !== ew || o_vcyc != ev) begin
      fails++; $display("FAIL bp_word got=%h@%0d exp=%h@%0d", o_data, o_vcyc, ew, ev);
    end
    for (int i = 0; i < 20; i++) begin
      raw_bit = 1'($urandom_range(0, 1));
      if (i == 10) enable = 1'b0;
      if (i == 12) enable = 1'b1;
      @(posedge clk); #1;
      if (rnd_valid !== 1'b1 || osc_run !== 1'b0 || rnd_data !== ew) errs++;
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL bp_hold got=%0d bad cycles exp=0", errs); end
    rnd_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (rnd_valid !== 1'b0 || osc_run !== 1'b1) begin
      fails++; $display("FAIL bp_restart valid=%b osc=%b exp valid=0 osc=1", rnd_valid, osc_run);
    end
    end_test();
  endtask

  task automatic test_restart();
    nsamp = 10;
    for (int p = 0; p < 5; p++) begin samp[2*p] = 1'b1; samp[2*p+1] = 1'b0; end
    drive_run(WU + 10*D + 4);
    tests++; if (o_vcyc != -1) begin fails++; $display("FAIL restart_early_valid got=%0d exp=-1", o_vcyc); end
    enable = 1'b0;
    @(posedge clk); #1;
    tests++; if (osc_run !== 1'b0) begin fails++; $display("FAIL restart_idle_osc got=%b exp=0", osc_run); end
    fill_alt(16);
    drive_run(300);
    tests++; if (o_vcyc != WU + 16*D + 1) begin fails++; $display("FAIL restart_valid_cycle got=%0d exp=%0d", o_vcyc, WU + 16*D + 1); end
    tests++; if (o_data !== 8'hAA) begin fails++; $display("FAIL restart_data got=%h exp=aa", o_data); end
    end_test();
  endtask

  task automatic test_stuck();
    logic [W-1:0] ew; int ev, ef;
    nsamp = 100;
    for (int k = 0; k < nsamp; k++) samp[k] = 1'b1;
    vn_model(ew, ev, ef);
    drive_run(WU + 100*D);
    tests++; if (o_vcyc != -1) begin fails++; $display("FAIL stuck_valid got=%0d exp=-1", o_vcyc); end
    tests++; if (o_fcyc != ef) begin fails++; $display("FAIL stuck_fault_cycle got=%0d exp=%0d", o_fcyc, ef); end
    tests++; if (o_bad != 0) begin fails++; $display("FAIL stuck_osc_before got=%0d exp=0", o_bad); end
`ifdef TRNG_HEALTH_EN
    tests++; if (osc_run !== 1'b0 || rnd_valid !== 1'b0) begin
      fails++; $display("FAIL stuck_fault_outputs osc=%b valid=%b exp 0 0", osc_run, rnd_valid);
    end
    enable = 1'b0;
    repeat (5) @(posedge clk); #1;
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL stuck_sticky got=%b exp=1", fault); end
    #2 reset = 1'b0;
    #1;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL stuck_reset_clear got=%b exp=0", fault); end
    @(posedge clk); #1 reset = 1'b1;
`else
    tests++; if (fault !== 1'b0 || osc_run !== 1'b1) begin
      fails++; $display("FAIL stuck_no_health fault=%b osc=%b exp fault=0 osc=1", fault, osc_run);
    end
`endif
    end_test();
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_discard();
    test_random();
    test_backpressure();
    test_restart();
    test_stuck();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trng_collector.md
# trng_collector

Consumer end of the ring-oscillator random source. It gates the oscillator on and off, samples its synchronised output bit at a fixed rate, and removes bias with a von Neumann pair extractor. It packs the unbiased bits into words and hands each word to game logic (Simon sequence generator) over a valid/ready handshake. An optional repetition-count health test latches a fault when the source sticks.

## Interface
Parameters:
- WORD_W, 8, bits per delivered random word (2..32)
- SAMPLE_DIV, 4, clocks between raw samples (≥1)
- WARMUP_CYC, 16, clocks the oscillator runs before sampling starts (≥1)
- REP_LIMIT, 32, identical consecutive samples that declare a fault (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- enable  in  1  request continuous word generation
- raw_bit  in  1  oscillator output, already two-flop synchronised
- osc_run  out  1  drives oscillator stop input; 1 = oscillate
- rnd_valid  out  1  rnd_data holds a complete word
- rnd_ready  in  1  consumer accepts word
- rnd_data  out  WORD_W  random word
- fault  out  1  sticky health-test failure

## Operation
- Reset values: state IDLE, osc_run=0, rnd_valid=0, rnd_data=0, fault=0, all counters 0.
- IDLE: osc_run=0. If enable=1, go to WARMUP.
- WARMUP: osc_run=1. Count WARMUP_CYC clocks, then go to COLLECT. No samples are taken.
- COLLECT: osc_run=1. Take one raw sample every SAMPLE_DIV clocks.
  - Samples pair up as (a,b).
  - If a≠b, shift a into the word LSB (word <= {word[WORD_W-2:0], a}) and increment the bit count.
  - If a=b, discard the pair.
  - When the bit count reaches WORD_W, load rnd_data and go to HOLD.
- HOLD: rnd_valid=1, osc_run=0. rnd_data stays stable. On rnd_valid&&rnd_ready, go to WARMUP if enable=1, else IDLE.
- enable=0 in WARMUP or COLLECT: go to IDLE next cycle and discard the partial word, pair state and counters.
- enable=0 in HOLD: ignored. The word is held until accepted.
- FAULT (health test only): osc_run=0, rnd_valid=0, fault=1. Exited only by reset.
- Bit and pair counters clear on every entry to COLLECT.

## Timing
- Sample strobe: divider counts 0..SAMPLE_DIV-1 from COLLECT entry. raw_bit is captured when the divider = SAMPLE_DIV-1. First sample is SAMPLE_DIV clocks after entry.
- rnd_valid rises on the clock after the strobe that completes the word.
- rnd_valid falls on the clock after the handshake. The earliest next word arrives ≥ WARMUP_CYC + 2·WORD_W·SAMPLE_DIV clocks later.
- osc_run transitions are registered. It rises the clock after leaving IDLE or HOLD.
- Health test: a run counter covers COLLECT samples only (paired or not). It resets to 1 when a sample differs from the previous sample. It resets on COLLECT entry.
- On the strobe where the run counter reaches REP_LIMIT, the block enters FAULT next clock. This takes priority over word completion on the same strobe.
- Reset asserted at any time returns all outputs to reset values asynchronously.

## Configuration
- TRNG_HEALTH_EN defined: repetition-count test and FAULT state are present; fault behaves as above.
- TRNG_HEALTH_EN not defined: no run counter and no FAULT state; fault is tied 0. A stuck source leaves the block in COLLECT indefinitely with rnd_valid=0.

## Structure
- Shared package trng_pkg holds:
  - the state enum (IDLE, WARMUP, COLLECT, HOLD, FAULT)
  - default constants for WORD_W, SAMPLE_DIV, WARMUP_CYC and REP_LIMIT
- One sub-module, vn_debias, is natural:
  - inputs: sample strobe, bit, clear
  - outputs: out_valid, out_bit
- FSM, divider, word shifter and health counter live in trng_collector.

## Test plan
All with default parameters unless stated.
- raw_bit alternates (1,0),(0,1) per pair for 16 samples, rnd_ready=1 -> rnd_data=0xAA; rnd_valid high exactly 1 clock, 16+64+1 clocks after enable rises.
- raw_bit gives pairs (1,1),(1,0)×8 -> the (1,1) pair is discarded; rnd_data=0xFF after 18 samples.
- rnd_ready=0 for 20 clocks after rnd_valid -> rnd_data stable, osc_run=0, rnd_valid held; accepting with enable=1 restarts WARMUP.
- enable dropped after 5 emitted bits, raised again -> full warmup; next word contains only post-restart bits (e.g. 0xAA pattern intact).
- raw_bit stuck at 1 with TRNG_HEALTH_EN -> fault=1 on the clock after the 32nd sample (129 clocks after COLLECT entry); osc_run=0; fault cleared only by reset.
- Same stimulus without TRNG_HEALTH_EN -> fault=0, rnd_valid never asserts, osc_run stays 1.
